icache_dm_refill: RTL



---
 rtl/icache_dm_refill.sv | 136 +++++++++++++
 1 files changed

// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache with valid bits, whole-cache flush and a
// word-per-beat line refill FSM for the fetch stage.
module icache_dm_refill #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINES      = 64,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              rd_en,
    input  logic              flush,
    output logic [31:0]       instr,
    output logic              hit,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_valid
);

    localparam int unsigned OFF_W = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned WPL   = LINE_BYTES / 4;
    localparam int unsigned CNT_W = (WPL > 1) ? $clog2(WPL) : 1;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                kill_q, kill_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LINES-1:0]    valid_q, valid_d;

    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [31:0]         data_arr [LINES][WPL];

    logic [TAG_W-1:0]    pc_tag;
    logic [IDX_W-1:0]    pc_idx;
    logic [CNT_W-1:0]    pc_word;
    logic [IDX_W-1:0]    line_idx;
    logic [TAG_W-1:0]    line_tag;
    logic                last_beat;
    logic                data_we;
    logic                tag_we;

    // Lookup path: fully combinational so a hit costs no cycles.
    always_comb begin
        pc_tag   = pc_addr[ADDR_W-1:OFF_W+IDX_W];
        pc_idx   = pc_addr[OFF_W+IDX_W-1:OFF_W];
        pc_word  = CNT_W'(pc_addr[OFF_W-1:0] >> 2);
        line_idx = base_q[OFF_W+IDX_W-1:OFF_W];
        line_tag = base_q[ADDR_W-1:OFF_W+IDX_W];

        hit      = valid_q[pc_idx] && (tag_arr[pc_idx] == pc_tag);
        instr    = data_arr[pc_idx][pc_word];
        stall    = (state_q != IDLE) || (rd_en && !hit);

        mem_req  = (state_q == REFILL);
        mem_addr = mem_req ? (base_q + ADDR_W'({cnt_q, 2'b00})) : '0;

        last_beat = (cnt_q == CNT_W'(WPL - 1));
        data_we   = mem_req && mem_valid;
        tag_we    = data_we && last_beat;
    end

    // Next-state: refill sequencing and valid-bit maintenance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        base_d  = base_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                if (rd_en && !hit && !flush) begin
                    state_d = REFILL;
                    base_d  = {pc_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    cnt_d   = '0;
                    kill_d  = 1'b0;
                end
            end
            REFILL: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (mem_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        valid_d[line_idx] = !(kill_q || flush);
                        state_d           = IDLE;
                        cnt_d             = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush drops every line, including one completing this cycle.
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            base_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            base_q  <= base_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_arr[line_idx][cnt_q] <= mem_rdata;
        end
        if (tag_we) begin
            tag_arr[line_idx] <= line_tag;
        end
    end

endmodule
